// File: rtl/mlp_pkg.sv
// Shared constants and state type for the MLP load sequencer and accelerator top.
// Word/row/group/layer geometry lives here so both sides agree on the load order.
package mlp_pkg;

    localparam int MLP_WORDS_PER_ROW  = 8;
    localparam int MLP_ROWS           = 16;
    localparam int MLP_WEIGHT_GROUPS  = 8;
    localparam int MLP_LAYERS         = 8;
    localparam int MLP_LAYER_GAP      = 4;
    localparam int MLP_RESULT_WORDS   = 128;
    localparam int MLP_WORD_CNT_W     = 7;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_LOAD_INPUT  = 3'd1,
        ST_LOAD_WEIGHT = 3'd2,
        ST_GAP         = 3'd3,
        ST_WAIT_RESULT = 3'd4
    } mlp_seq_state_t;

    function automatic logic is_load_state(input mlp_seq_state_t s);
        return (s == ST_LOAD_INPUT) || (s == ST_LOAD_WEIGHT);
    endfunction

endpackage

// File: rtl/mlp_load_idx.sv
// Word and layer counters for the load sequencer, plus the row/group/layer
// index decode for the input phase and the weight phase.
module mlp_load_idx
    import mlp_pkg::*;
#(
    parameter int WORDS_PER_ROW = MLP_WORDS_PER_ROW,
    parameter int ROWS          = MLP_ROWS,
    parameter int WEIGHT_GROUPS = MLP_WEIGHT_GROUPS,
    parameter int LAYERS        = MLP_LAYERS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       word_inc,
    input  logic       layer_inc,
    input  logic       weight_phase,
    output logic       word_last,
    output logic       layer_last,
    output logic [3:0] input_load_number,
    output logic [3:0] weight_number,
    output logic [2:0] layer_number
);

    localparam logic [MLP_WORD_CNT_W-1:0] INPUT_LAST  = MLP_WORD_CNT_W'(WORDS_PER_ROW * ROWS - 1);
    localparam logic [MLP_WORD_CNT_W-1:0] WEIGHT_LAST = MLP_WORD_CNT_W'(ROWS * WEIGHT_GROUPS - 1);
    localparam logic [2:0]                LAYER_LAST  = 3'(LAYERS - 1);

    logic [MLP_WORD_CNT_W-1:0] word_cnt;
    logic [2:0]                layer_cnt;

    assign word_last  = weight_phase ? (word_cnt == WEIGHT_LAST) : (word_cnt == INPUT_LAST);
    assign layer_last = (layer_cnt == LAYER_LAST);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            word_cnt  <= '0;
            layer_cnt <= '0;
        end else begin
            if (word_inc) begin
                word_cnt <= word_last ? '0 : word_cnt + 1'b1;
            end
            if (layer_inc) begin
                layer_cnt <= layer_cnt + 3'd1;
            end
        end
    end

    // Input rows are 8 words wide; weight groups are 16 rows of one word each.
    always_comb begin
        weight_number = {1'b0, word_cnt[6:4]};
        if (weight_phase) begin
            input_load_number = word_cnt[3:0];
            layer_number      = layer_cnt;
        end else begin
            input_load_number = word_cnt[6:3];
            layer_number      = 3'd0;
        end
    end

endmodule

// File: rtl/mlp_load_sequencer.sv
// Turns a flat host word stream into the accelerator's ordered input/weight
// load strobes, inserts inter-layer gaps, then waits for the result burst.
module mlp_load_sequencer
    import mlp_pkg::*;
#(
    parameter int WORDS_PER_ROW = MLP_WORDS_PER_ROW,
    parameter int ROWS          = MLP_ROWS,
    parameter int WEIGHT_GROUPS = MLP_WEIGHT_GROUPS,
    parameter int LAYERS        = MLP_LAYERS,
    parameter int LAYER_GAP     = MLP_LAYER_GAP,
    parameter int RESULT_WORDS  = MLP_RESULT_WORDS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        host_valid_i,
    input  logic [31:0] host_data_i,
    output logic        host_ready_o,
    output logic        load_en_o,
    output logic [31:0] load_payload_o,
    output logic        load_type_o,
    output logic [3:0]  input_load_number_o,
    output logic [2:0]  layer_number_o,
    output logic [3:0]  weight_number_o,
    input  logic        result_valid_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [2:0]  state_o
);

    // Handshake: a host word is consumed on a rising edge exactly when
    // host_valid_i and host_ready_o are both high; host_ready_o depends on state only.

    localparam logic [7:0]  GAP_LAST = 8'(LAYER_GAP - 1);
    localparam logic [15:0] RES_LAST = 16'(RESULT_WORDS - 1);

    mlp_seq_state_t state, state_next;

    logic        accept;
    logic        cnt_clear;
    logic        layer_inc;
    logic        done_next;
    logic        word_last;
    logic        layer_last;
    logic [3:0]  idx_input;
    logic [3:0]  idx_weight;
    logic [2:0]  idx_layer;
    logic [7:0]  gap_cnt;
    logic [15:0] res_cnt;

    assign host_ready_o = is_load_state(state);
    assign accept       = host_ready_o && host_valid_i;
    assign state_o      = state;

    mlp_load_idx #(
        .WORDS_PER_ROW (WORDS_PER_ROW),
        .ROWS          (ROWS),
        .WEIGHT_GROUPS (WEIGHT_GROUPS),
        .LAYERS        (LAYERS)
    ) u_idx (
        .clk               (clk),
        .rst               (rst),
        .clear             (cnt_clear),
        .word_inc          (accept),
        .layer_inc         (layer_inc),
        .weight_phase      (state == ST_LOAD_WEIGHT),
        .word_last         (word_last),
        .layer_last        (layer_last),
        .input_load_number (idx_input),
        .weight_number     (idx_weight),
        .layer_number      (idx_layer)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_clear  = 1'b0;
        layer_inc  = 1'b0;
        done_next  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_i) begin
                    state_next = ST_LOAD_INPUT;
                    cnt_clear  = 1'b1;
                end
            end
            ST_LOAD_INPUT: begin
                if (accept && word_last) begin
                    state_next = ST_LOAD_WEIGHT;
                end
            end
            ST_LOAD_WEIGHT: begin
                if (accept && word_last) begin
                    if (layer_last) begin
                        state_next = ST_WAIT_RESULT;
                    end else begin
                        state_next = ST_GAP;
                        layer_inc  = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_next = ST_LOAD_WEIGHT;
                end
            end
            ST_WAIT_RESULT: begin
                if (result_valid_i && (res_cnt == RES_LAST)) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clear) begin
            gap_cnt <= '0;
            res_cnt <= '0;
        end else begin
            if (state == ST_GAP) begin
                gap_cnt <= (gap_cnt == GAP_LAST) ? '0 : gap_cnt + 8'd1;
            end
            if ((state == ST_WAIT_RESULT) && result_valid_i) begin
                res_cnt <= res_cnt + 16'd1;
            end
        end
    end

    // Without a strobe the type line idles at 1 so the array holds; indices keep their values.
    always_ff @(posedge clk) begin
        if (rst) begin
            load_en_o           <= 1'b0;
            load_payload_o      <= '0;
            load_type_o         <= 1'b1;
            input_load_number_o <= '0;
            layer_number_o      <= '0;
            weight_number_o     <= '0;
            busy_o              <= 1'b0;
            done_o              <= 1'b0;
        end else begin
            load_en_o <= accept;
            busy_o    <= (state_next != ST_IDLE);
            done_o    <= done_next;
            if (accept) begin
                load_payload_o      <= host_data_i;
                load_type_o         <= (state == ST_LOAD_INPUT);
                input_load_number_o <= idx_input;
                layer_number_o      <= idx_layer;
                if (state == ST_LOAD_WEIGHT) begin
                    weight_number_o <= idx_weight;
                end
            end else begin
                load_type_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mlp_load_sequencer.sv
// Self-checking bench for mlp_load_sequencer: a word-count based model compared
// every cycle, plus literal checks at reset, index boundaries, gaps and completion.
module tb_mlp_load_sequencer;

    localparam int PHASE        = 128;
    localparam int LAYERS       = 8;
    localparam int LAYER_GAP    = 4;
    localparam int RESULT_WORDS = 128;
    localparam int TOTAL_WORDS  = PHASE * (LAYERS + 1);

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        host_valid_i;
    logic [31:0] host_data_i;
    logic        host_ready_o;
    logic        load_en_o;
    logic [31:0] load_payload_o;
    logic        load_type_o;
    logic [3:0]  input_load_number_o;
    logic [2:0]  layer_number_o;
    logic [3:0]  weight_number_o;
    logic        result_valid_i;
    logic        busy_o;
    logic        done_o;
    logic [2:0]  state_o;

    always #5 clk = ~clk;

    mlp_load_sequencer dut (
        .clk                 (clk),
        .rst                 (rst),
        .start_i             (start_i),
        .host_valid_i        (host_valid_i),
        .host_data_i         (host_data_i),
        .host_ready_o        (host_ready_o),
        .load_en_o           (load_en_o),
        .load_payload_o      (load_payload_o),
        .load_type_o         (load_type_o),
        .input_load_number_o (input_load_number_o),
        .layer_number_o      (layer_number_o),
        .weight_number_o     (weight_number_o),
        .result_valid_i      (result_valid_i),
        .busy_o              (busy_o),
        .done_o              (done_o),
        .state_o             (state_o)
    );

    int total_checks  = 0;
    int passed_checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_checks++;
        if (act === exp) passed_checks++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- model: outputs derived from the count of accepted words
    int          m_phase = 0;   // 0 idle, 1 loading, 2 gap, 3 waiting for results
    int          m_k     = 0;   // words accepted in this inference
    int          m_gap   = 0;
    int          m_res   = 0;
    bit          model_on = 0;
    logic        exp_ready, exp_en, exp_type, exp_busy, exp_done;
    logic [31:0] exp_payload;
    logic [3:0]  exp_in, exp_wt;
    logic [2:0]  exp_layer;

    always @(posedge clk) begin
        int j;
        model_on = 1;
        if (rst) begin
            m_phase = 0; m_k = 0; m_gap = 0; m_res = 0;
            exp_en = 0; exp_payload = 0; exp_type = 1; exp_done = 0;
            exp_in = 0; exp_wt = 0; exp_layer = 0;
        end else begin
            exp_en = 0; exp_done = 0; exp_type = 1;
            case (m_phase)
                0: if (start_i) begin m_phase = 1; m_k = 0; m_res = 0; end
                1: if (host_valid_i) begin
                    exp_en = 1;
                    exp_payload = host_data_i;
                    if (m_k < PHASE) begin
                        exp_type  = 1;
                        exp_layer = 0;
                        exp_in    = 4'(m_k / 8);
                    end else begin
                        j = m_k - PHASE;
                        exp_type  = 0;
                        exp_layer = 3'(j / PHASE);
                        exp_wt    = 4'((j % PHASE) / 16);
                        exp_in    = 4'(j % 16);
                    end
                    m_k++;
                    if (m_k == TOTAL_WORDS) m_phase = 3;
                    else if (m_k > PHASE && (m_k - PHASE) % PHASE == 0) begin
                        m_phase = 2; m_gap = LAYER_GAP;
                    end
                end
                2: begin m_gap--; if (m_gap == 0) m_phase = 1; end
                3: if (result_valid_i) begin
                    m_res++;
                    if (m_res == RESULT_WORDS) begin exp_done = 1; m_phase = 0; end
                end
                default: m_phase = 0;
            endcase
        end
        exp_ready = (m_phase == 1);
        exp_busy  = (m_phase != 0);
    end

    always @(negedge clk) begin
        if (model_on) begin
            check("host_ready", host_ready_o, exp_ready);
            check("load_en", load_en_o, exp_en);
            check("load_type", load_type_o, exp_type);
            check("payload", load_payload_o, exp_payload);
            check("input_idx", input_load_number_o, exp_in);
            check("weight_idx", weight_number_o, exp_wt);
            check("layer_idx", layer_number_o, exp_layer);
            check("busy", busy_o, exp_busy);
            check("done", done_o, exp_done);
        end
    end

    // ---------------- monitors: not-ready runs while busy, done pulses
    int gap_q[$];
    int gap_run  = 0;
    int done_cnt = 0;

    always @(negedge clk) begin
        if (busy_o === 1'b1 && host_ready_o === 1'b0) gap_run++;
        else begin
            if (gap_run > 0 && host_ready_o === 1'b1) gap_q.push_back(gap_run);
            gap_run = 0;
        end
        if (done_o === 1'b1) done_cnt++;
    end

    // ---------------- drivers
    task automatic cycle();
        @(posedge clk); #1;
    endtask

    task automatic do_start();
        start_i = 1; cycle(); start_i = 0;
    endtask

    task automatic bubble(input int n);
        host_valid_i = 0;
        repeat (n) cycle();
    endtask

    task automatic send_word(input logic [31:0] data);
        bit acc;
        int waited;
        host_valid_i = 1; host_data_i = data; acc = 0; waited = 0;
        while (!acc && waited < 100) begin
            @(negedge clk); acc = host_ready_o;
            cycle();
            waited++;
        end
        host_valid_i = 0;
        if (!acc) begin
            total_checks++;
            $display("FAIL send_word_timeout: got no accept, expected accept within 100 cycles");
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_en"}, load_en_o, 0);
        check({tag, "_type"}, load_type_o, 1);
        check({tag, "_payload"}, load_payload_o, 0);
        check({tag, "_in"}, input_load_number_o, 0);
        check({tag, "_wt"}, weight_number_o, 0);
        check({tag, "_layer"}, layer_number_o, 0);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_ready"}, host_ready_o, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected run to finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1; start_i = 0; host_valid_i = 0; host_data_i = 0; result_valid_i = 0;
        repeat (3) cycle();
        check_reset_values("por");
        rst = 0;

        // inference A: full input phase, partial layer-0 weights, then abort
        do_start();
        check("start_ready", host_ready_o, 1);
        for (int k = 0; k < PHASE; k++) begin
            send_word(32'(k));
            if (k == 0)   check("in_w0_idx", input_load_number_o, 0);
            if (k == 8)   check("in_w8_idx", input_load_number_o, 1);
            if (k == 127) begin
                check("in_w127_idx", input_load_number_o, 15);
                check("in_w127_type", load_type_o, 1);
                check("in_w127_payload", load_payload_o, 127);
            end
        end
        for (int k = 0; k < 60; k++) begin
            send_word(32'hB000_0000 + 32'(k));
            if (k == 59) begin
                check("wA_w59_wt", weight_number_o, 3);
                check("wA_w59_in", input_load_number_o, 11);
                check("wA_w59_layer", layer_number_o, 0);
            end
            if (k % 5 == 2) bubble(2);
        end
        rst = 1;
        repeat (3) cycle();
        check_reset_values("abort");
        rst = 0;
        cycle();

        // inference B: complete run with bubbles, stray result_valid while loading
        gap_q.delete();
        done_cnt = 0;
        do_start();
        for (int k = 0; k < TOTAL_WORDS; k++) begin
            if (k == 200) result_valid_i = 1;
            send_word(32'h5A00_0000 ^ (32'(k) * 32'h0001_0101));
            if (k == PHASE) begin
                check("wB_first_type", load_type_o, 0);
                check("wB_first_wt", weight_number_o, 0);
            end
            if (k == PHASE + 3 * PHASE + 37) begin
                check("l3_w37_wt", weight_number_o, 2);
                check("l3_w37_in", input_load_number_o, 5);
                check("l3_w37_layer", layer_number_o, 3);
                check("l3_w37_type", load_type_o, 0);
            end
            if (k >= PHASE && $urandom_range(0, 3) == 0) bubble($urandom_range(1, 3));
        end
        result_valid_i = 0;
        check("gap_count", gap_q.size(), LAYERS - 1);
        foreach (gap_q[i]) check("gap_len", gap_q[i], LAYER_GAP);
        check("wait_busy", busy_o, 1);

        for (int i = 0; i < 138; i++) begin
            result_valid_i = !(i inside {3, 17, 29, 40, 55, 61, 77, 90, 101, 120});
            start_i = (i == 50);
            cycle();
        end
        result_valid_i = 0; start_i = 0;
        check("done_at_128", done_o, 1);
        check("busy_drop", busy_o, 0);
        repeat (3) cycle();
        check("done_pulses", done_cnt, 1);
        check("end_ready", host_ready_o, 0);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule

// File: doc/mlp_load_sequencer.md
# mlp_load_sequencer

- Upstream feeder for the MLP accelerator top.
- Accepts a flat host word stream over a valid/ready handshake and re-emits it as the accelerator's load strobe, payload, type and index signals, in the fixed layer/row/weight-group order the accelerator expects.
- Then waits for the accelerator's result burst and signals completion.
- Sits between the host DMA/FIFO and the accelerator top.

## Interface
Parameters:
- WORDS_PER_ROW, 8: 32-bit words per 256-bit input row.
- ROWS, 16: input rows / rows per weight group.
- WEIGHT_GROUPS, 8: weight groups per layer (weight_number range).
- LAYERS, 8: layers per inference.
- LAYER_GAP, 4: idle cycles inserted after each of layers 0..LAYERS-2.
- RESULT_WORDS, 128: result_valid_i cycles counted before done.

Ports:
- clk, in, 1: clock. Single clock domain.
- rst, in, 1: reset, synchronous, active-high.
- start_i, in, 1: begin one inference; sampled in IDLE only.
- host_valid_i, in, 1: host word valid.
- host_data_i, in, 32: host word.
- host_ready_o, out, 1: sequencer accepts a word this cycle.
- load_en_o, out, 1: payload strobe to the accelerator.
- load_payload_o, out, 32: registered host word.
- load_type_o, out, 1: 1 = input or hold, 0 = weight.
- input_load_number_o, out, 4: row index 0-15.
- layer_number_o, out, 3: layer 0-7.
- weight_number_o, out, 4: weight group 0-7; bit 3 always 0.
- result_valid_i, in, 1: accelerator result valid.
- busy_o, out, 1: high in every state except IDLE.
- done_o, out, 1: one-cycle completion pulse.

## Operation
States: IDLE, LOAD_INPUT, LOAD_WEIGHT, GAP, WAIT_RESULT.

- **IDLE:** start_i=1 moves to LOAD_INPUT and clears word_cnt (7 bit), layer_cnt (3 bit) and gap_cnt.
- **LOAD_INPUT:** host_ready_o=1.
  - Each accepted word (host_valid_i && host_ready_o) increments word_cnt.
  - Registered outputs: load_type_o=1, layer_number_o=0, input_load_number_o=word_cnt[6:3].
  - After word 127 is accepted: word_cnt wraps to 0 and the state moves to LOAD_WEIGHT.
- **LOAD_WEIGHT:** host_ready_o=1.
  - Per accepted word: load_type_o=0, weight_number_o={1'b0,word_cnt[6:4]}, input_load_number_o=word_cnt[3:0], layer_number_o=layer_cnt.
  - After word 127 is accepted:
    - If layer_cnt==LAYERS-1, go to WAIT_RESULT.
    - Otherwise go to GAP with layer_cnt incremented.
- **GAP:** host_ready_o=0 for LAYER_GAP cycles, then return to LOAD_WEIGHT.
- **WAIT_RESULT:**
  - host_ready_o=0.
  - Count cycles with result_valid_i=1.
  - On count RESULT_WORDS: done_o=1 for one cycle, go to IDLE.
- **Bubbles:** host_valid_i=0 in a load state gives load_en_o=0 and leaves all counters unchanged. Bubbles are legal and unbounded.
- **Idle outputs:** whenever load_en_o=0, load_type_o=1, so the array holds. Index outputs keep their last values.
- **Ignored inputs:**
  - start_i outside IDLE.
  - result_valid_i outside WAIT_RESULT.
  - host_valid_i when host_ready_o=0; no word is consumed.

## Timing
- Reset values, on the first rising edge with rst=1:
  - State IDLE; all counters 0.
  - host_ready_o=0, load_en_o=0, load_payload_o=0, load_type_o=1, all indices 0, busy_o=0, done_o=0.
- All outputs are registered except host_ready_o, which is a combinational decode of state.
- Latency: a word accepted at edge N appears with load_en_o=1 in the cycle after edge N (one-cycle latency).
- start_i at edge N: host_ready_o=1 in the cycle after edge N.
- Best case: 1024 + 128 + 7×LAYER_GAP accepted-word cycles before WAIT_RESULT.
- done_o asserts the cycle after the 128th result_valid_i=1 sample. busy_o drops in that same cycle.
- rst=1 mid-operation aborts immediately; the next start_i restarts from layer 0 input row 0.

## Structure
- Shared package `mlp_pkg`:
  - typedef enum `mlp_seq_state_t` (five states).
  - Constants for words per row, rows, groups, layers and result words, reused by the accelerator top.
- One natural sub-module: `mlp_load_idx`.
  - Holds word_cnt and layer_cnt with increment/clear/wrap.
  - Decodes input_load_number, weight_number and layer_number for both phases.
- The FSM and output registers stay in the top.

## Test plan
- **Reset:** hold rst 3 cycles mid-LOAD_WEIGHT -> all outputs at reset values, busy_o=0, a new start_i works.
- **Input phase:** start_i, then 128 back-to-back words 0..127 -> load_en_o 128 cycles, load_type_o=1, input_load_number_o steps 0..15 every 8 words, payload equals data one cycle later.
- **Weight indexing:** during layer 3 weights, word 37 -> weight_number_o=2, input_load_number_o=5, layer_number_o=3, load_type_o=0.
- **Gap and bubbles:**
  - Random host_valid_i gaps -> indices advance only on accepts.
  - After each of layers 0..6, exactly 4 cycles with host_ready_o=0.
  - No gap after layer 7.
- **Completion:** 128 result_valid_i cycles with 10 interleaved low cycles -> single done_o pulse after the 128th. start_i during WAIT_RESULT is ignored.
